// File: rtl/writeback_register_unit_pkg.sv
// Shared constants for the stage-4 write-back unit.
//   DATA_W     datapath width
//   NUM_REGS   general registers R0..R7 (R0 = accumulator)
//   NUM_PORTS  output port registers
//   SP_RESET   stack pointer value after reset
//   R0_IDX     register index of the accumulator
package writeback_register_unit_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned NUM_PORTS  = 8;
  localparam int unsigned REG_IDX_W  = 3;
  localparam int unsigned PORT_IDX_W = 3;

  localparam logic [DATA_W-1:0]    SP_RESET = 8'hFF;
  localparam logic [REG_IDX_W-1:0] R0_IDX   = '0;

endpackage

// File: rtl/writeback_register_unit_if.sv
// Stage-4 write-back command and result bus.
//   master: control generator / operand fetch side (drives strobes, selects, data)
//   slave : writeback_register_unit (returns bypassed reads, SP, ports, flags)
interface writeback_register_unit_if;
  import writeback_register_unit_pkg::*;

  logic                          LRN;
  logic                          LR0;
  logic                          LSP;
  logic                          DSP;
  logic                          ISP;
  logic                          LOP;
  logic                          ERN;
  logic [REG_IDX_W-1:0]          rn_sel;
  logic [PORT_IDX_W-1:0]         pn_sel;
  logic [DATA_W-1:0]             wb_data;
  logic [DATA_W-1:0]             acc_data;
  logic [REG_IDX_W-1:0]          rd_sel_a;
  logic [REG_IDX_W-1:0]          rd_sel_b;
  logic [DATA_W-1:0]             rd_data_a;
  logic [DATA_W-1:0]             rd_data_b;
  logic [DATA_W-1:0]             rn_out;
  logic [DATA_W-1:0]             sp_out;
  logic [NUM_PORTS*DATA_W-1:0]   out_ports;
  logic [NUM_PORTS-1:0]          out_strobe;
  logic                          sp_uflow;

  modport master (
    output LRN, LR0, LSP, DSP, ISP, LOP, ERN,
    output rn_sel, pn_sel, wb_data, acc_data, rd_sel_a, rd_sel_b,
    input  rd_data_a, rd_data_b, rn_out, sp_out, out_ports, out_strobe, sp_uflow
  );

  modport slave (
    input  LRN, LR0, LSP, DSP, ISP, LOP, ERN,
    input  rn_sel, pn_sel, wb_data, acc_data, rd_sel_a, rd_sel_b,
    output rd_data_a, rd_data_b, rn_out, sp_out, out_ports, out_strobe, sp_uflow
  );

endinterface

// File: rtl/writeback_register_unit_gpr_file.sv
// General register file: one indexed write port plus an R0 override port,
// two bypassed read ports and one raw (stored-value) read port.
//   clk, rst               clock, async active-high reset
//   we_rn/rn_sel/rn_data   indexed write
//   we_r0/r0_data          accumulator write, wins over an indexed write to R0
//   rd_sel_a/b, rd_data_*  reads that see this cycle's write
//   raw_sel, raw_data_c    read of the stored value only
module gpr_file
  import writeback_register_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_rn,
  input  logic [REG_IDX_W-1:0] rn_sel,
  input  logic [DATA_W-1:0]    rn_data,
  input  logic                 we_r0,
  input  logic [DATA_W-1:0]    r0_data,
  input  logic [REG_IDX_W-1:0] rd_sel_a,
  input  logic [REG_IDX_W-1:0] rd_sel_b,
  input  logic [REG_IDX_W-1:0] raw_sel,
  output logic [DATA_W-1:0]    rd_data_a_c,
  output logic [DATA_W-1:0]    rd_data_b_c,
  output logic [DATA_W-1:0]    raw_data_c
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Next register image; the R0 write is applied last so it wins.
  always_comb begin
    regs_d = regs_q;
    if (we_rn) regs_d[rn_sel] = rn_data;
    if (we_r0) regs_d[R0_IDX] = r0_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Bypass by reading the next image; raw port sees storage only.
  assign rd_data_a_c = regs_d[rd_sel_a];
  assign rd_data_b_c = regs_d[rd_sel_b];
  assign raw_data_c  = regs_q[raw_sel];

endmodule

// File: rtl/writeback_register_unit.sv
// Stage-4 write-back sink: commits register, stack pointer and output-port
// updates from the control strobes and returns bypassed values upstream.
//   clk, rst  clock, async active-high reset
//   bus       writeback_register_unit_if.slave (strobes, selects, data in;
//             rd_data_a/b, rn_out, sp_out, out_ports, out_strobe, sp_uflow out)
module writeback_register_unit
  import writeback_register_unit_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  writeback_register_unit_if.slave   bus
);

  logic [DATA_W-1:0]    sp_q, sp_d;
  logic                 sp_uflow_q, sp_uflow_d;
  logic [DATA_W-1:0]    port_q [NUM_PORTS];
  logic [DATA_W-1:0]    port_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] out_strobe_q, out_strobe_d;
  logic [DATA_W-1:0]    raw_data_c;

  gpr_file u_gpr_file (
    .clk         (clk),
    .rst         (rst),
    .we_rn       (bus.LRN),
    .rn_sel      (bus.rn_sel),
    .rn_data     (bus.wb_data),
    .we_r0       (bus.LR0),
    .r0_data     (bus.acc_data),
    .rd_sel_a    (bus.rd_sel_a),
    .rd_sel_b    (bus.rd_sel_b),
    .raw_sel     (bus.rn_sel),
    .rd_data_a_c (bus.rd_data_a),
    .rd_data_b_c (bus.rd_data_b),
    .raw_data_c  (raw_data_c)
  );

  // Stack pointer: load beats step; opposing steps cancel. A wrap sets the
  // sticky flag, which only a load clears.
  always_comb begin
    sp_d       = sp_q;
    sp_uflow_d = sp_uflow_q;
    if (bus.LSP) begin
      sp_d       = bus.wb_data;
      sp_uflow_d = 1'b0;
    end else if (bus.DSP && !bus.ISP) begin
      sp_d = sp_q - DATA_W'(1);
      if (sp_q == '0) sp_uflow_d = 1'b1;
    end else if (bus.ISP && !bus.DSP) begin
      sp_d = sp_q + DATA_W'(1);
      if (sp_q == '1) sp_uflow_d = 1'b1;
    end
  end

  // Output ports and the one-hot update strobe for the following cycle.
  always_comb begin
    port_d       = port_q;
    out_strobe_d = '0;
    if (bus.LOP) begin
      port_d[bus.pn_sel]       = bus.acc_data;
      out_strobe_d[bus.pn_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q         <= SP_RESET;
      sp_uflow_q   <= 1'b0;
      port_q       <= '{default: '0};
      out_strobe_q <= '0;
    end else begin
      sp_q         <= sp_d;
      sp_uflow_q   <= sp_uflow_d;
      port_q       <= port_d;
      out_strobe_q <= out_strobe_d;
    end
  end

  always_comb begin
    bus.out_ports = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.out_ports[i*DATA_W +: DATA_W] = port_q[i];
    end
  end

  assign bus.sp_out     = sp_d;
  assign bus.sp_uflow   = sp_uflow_q;
  assign bus.out_strobe = out_strobe_q;
  assign bus.rn_out     = bus.ERN ? raw_data_c : '0;

endmodule
